// File: rtl/vscale_htif_pcr_arb_pkg.sv
// Shared constants for the HTIF PCR arbiter: channel width, FSM encoding, watchdog default
// and the host-facing CSR addresses.
package vscale_htif_pcr_arb_pkg;

  localparam int unsigned HtifPcrWidth   = 64;
  localparam int unsigned HtifArbTimeout = 1024;

  localparam logic [11:0] HtifCsrTohost   = 12'h780;
  localparam logic [11:0] HtifCsrFromhost = 12'h781;

  typedef enum logic [1:0] {
    HtifArbIdle    = 2'd0,
    HtifArbIssue   = 2'd1,
    HtifArbWait    = 2'd2,
    HtifArbDeliver = 2'd3
  } htif_arb_state_e;

endpackage

// File: rtl/vscale_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping.
module vscale_rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IdxW-1:0] last_grant_i,
  output logic [NREQ-1:0] grant_oh_o,
  output logic [IdxW-1:0] grant_idx_o,
  output logic            any_o
);

  int unsigned idx;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = (int'(last_grant_i) + off) % NREQ;
      if (!any_o && valid_i[idx]) begin
        any_o           = 1'b1;
        grant_oh_o[idx] = 1'b1;
        grant_idx_o     = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/vscale_htif_pcr_arb.sv
// Shares the core-side HTIF PCR channel between NREQ host requesters, one transaction at a
// time, with a watchdog that turns a silent core into an error response.
module vscale_htif_pcr_arb
  import vscale_htif_pcr_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned DATA_WIDTH = HtifPcrWidth,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT    = HtifArbTimeout
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_rw,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            resp_valid,
  input  logic [NREQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]      resp_data,
  output logic                       resp_err,
  output logic                       pcr_req_valid,
  input  logic                       pcr_req_ready,
  output logic                       pcr_req_rw,
  output logic [ADDR_WIDTH-1:0]      pcr_req_addr,
  output logic [DATA_WIDTH-1:0]      pcr_req_data,
  input  logic                       pcr_resp_valid,
  output logic                       pcr_resp_ready,
  input  logic [DATA_WIDTH-1:0]      pcr_resp_data
);

  localparam int unsigned IdxW  = $clog2(NREQ);
  localparam int unsigned WdogW = $clog2(TIMEOUT);

  htif_arb_state_e       state_q, state_d;
  logic [IdxW-1:0]       last_grant_q, last_grant_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [WdogW-1:0]      wdog_q, wdog_d;

  logic [NREQ-1:0]       pick_oh;
  logic [IdxW-1:0]       pick_idx;
  logic                  pick_any;

  logic [ADDR_WIDTH-1:0] addr_arr [NREQ];
  logic [DATA_WIDTH-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  vscale_rr_pick #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_oh_o   (pick_oh),
    .grant_idx_o  (pick_idx),
    .any_o        (pick_any)
  );

  // Captured request and response registers drive the data outputs directly so they hold
  // steady for as long as the corresponding valid is asserted.
  assign pcr_req_rw   = rw_q;
  assign pcr_req_addr = addr_q;
  assign pcr_req_data = wdata_q;
  assign resp_data    = rdata_q;
  assign resp_err     = err_q;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    rw_d           = rw_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    wdog_d         = wdog_q;
    req_ready      = '0;
    resp_valid     = '0;
    pcr_req_valid  = 1'b0;
    pcr_resp_ready = 1'b0;

    unique case (state_q)
      HtifArbIdle: begin
        // No accept while reset is held, so a request is never half-taken across reset.
        if (pick_any && reset) begin
          req_ready    = pick_oh;
          rw_d         = req_rw[pick_idx];
          addr_d       = addr_arr[pick_idx];
          wdata_d      = data_arr[pick_idx];
          owner_d      = pick_idx;
          last_grant_d = pick_idx;
          state_d      = HtifArbIssue;
        end
      end
      HtifArbIssue: begin
        pcr_req_valid = 1'b1;
        if (pcr_req_ready) begin
          wdog_d  = '0;
          state_d = HtifArbWait;
        end
      end
      HtifArbWait: begin
        pcr_resp_ready = 1'b1;
        wdog_d         = wdog_q + 1'b1;
        // A response in the same cycle as the watchdog expiry takes priority.
        if (pcr_resp_valid) begin
          rdata_d = pcr_resp_data;
          err_d   = 1'b0;
          state_d = HtifArbDeliver;
        end else if (wdog_q == WdogW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = HtifArbDeliver;
        end
      end
      HtifArbDeliver: begin
        resp_valid = NREQ'(1) << owner_q;
        if (resp_ready[owner_q]) begin
          state_d = HtifArbIdle;
        end
      end
      default: state_d = HtifArbIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= HtifArbIdle;
      last_grant_q <= IdxW'(NREQ - 1);
      owner_q      <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      wdog_q       <= wdog_d;
    end
  end

endmodule
